fp_divider: RTL and testbench



---
 rtl/fp_pkg.sv | 25 ++
 rtl/fp_div_mant_core.sv | 43 ++++
 rtl/fp_divider.sv | 148 ++++++++++++++
 tb/tb_fp_divider.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the FP datapath (single precision).
// Holds field widths, special encodings, the divider FSM states and operand classification.
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam logic [EXP_W+MAN_W:0] FP_INF  = 32'h7F80_0000;
    localparam logic [EXP_W+MAN_W:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {IDLE, DIV, NORM, SPEC} state_t;

    typedef enum logic [1:0] {CLS_NORM, CLS_INF, CLS_ZERO} fp_cls_t;

    // Priority matters: a NaN/Inf operand wins over a zero dividend, which wins over a zero divisor.
    function automatic fp_cls_t fp_div_classify(input logic [EXP_W-1:0] ea,
                                                input logic [EXP_W-1:0] eb);
        if (ea == '1 || eb == '1) return CLS_INF;
        if (ea == '0)             return CLS_ZERO;
        if (eb == '0)             return CLS_INF;
        return CLS_NORM;
    endfunction

endpackage

// File: rtl/fp_div_mant_core.sv
// Restoring mantissa divider: one quotient bit per step, MAN_W+3 steps per operation.
module fp_div_mant_core #(
    parameter int MAN_W = 23
) (
    input  logic             clk,
    input  logic             load,
    input  logic             step,
    input  logic [MAN_W-1:0] ma,
    input  logic [MAN_W-1:0] mb,
    output logic [MAN_W+2:0] q,
    output logic             rem_nonzero,
    output logic             last
);
    localparam int Q     = MAN_W + 3;
    localparam int CNT_W = $clog2(Q);

    // rem stays below 2*dv, so one bit above the 24-bit mantissa is enough
    logic [MAN_W+1:0] rem;
    logic [MAN_W:0]   dv;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (load) begin
            rem <= {1'b0, 1'b1, ma};
            dv  <= {1'b1, mb};
            q   <= '0;
            cnt <= '0;
        end else if (step) begin
            if (rem >= {1'b0, dv}) begin
                rem <= (rem - {1'b0, dv}) << 1;
                q   <= {q[Q-2:0], 1'b1};
            end else begin
                rem <= rem << 1;
                q   <= {q[Q-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
        end
    end

    assign rem_nonzero = |rem;
    assign last        = (cnt == CNT_W'(Q - 1));

endmodule

// File: rtl/fp_divider.sv
// Iterative single-precision divider out = a / b with start/busy/done handshake.
// Optional macro FP_DIV_ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation.
module fp_divider #(
    parameter int EXP_W = fp_pkg::EXP_W,
    parameter int MAN_W = fp_pkg::MAN_W,
    parameter int BIAS  = fp_pkg::BIAS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   out
);
    import fp_pkg::*;

    localparam int W = EXP_W + MAN_W + 1;
    localparam int Q = MAN_W + 3;
    localparam logic signed [EXP_W+1:0] E_ONES = (EXP_W+2)'((1 << EXP_W) - 1);
    localparam logic signed [EXP_W+1:0] BIAS_E = (EXP_W+2)'(BIAS);
    localparam logic signed [EXP_W+1:0] ONE_E  = (EXP_W+2)'(1);

    state_t                   state, state_nxt;
    logic                     acc, load, step, fin;
    fp_cls_t                  cls;
    logic                     sign_r;
    logic signed [EXP_W+1:0]  e_base;
    logic [W-1:0]             spec_r;
    logic [Q-1:0]             q;
    logic                     rem_nz, last;
    logic signed [EXP_W+1:0]  e_n, e_rd;
    logic [MAN_W-1:0]         mant, mant_rd;
    logic [W-1:0]             norm_res;

    function automatic logic [W-1:0] pack_res(input logic s,
                                              input logic signed [EXP_W+1:0] e,
                                              input logic [MAN_W-1:0] m);
        if (e >= E_ONES) return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        if (e <= 0)      return {s, {(W-1){1'b0}}};
        return {s, e[EXP_W-1:0], m};
    endfunction

`ifdef FP_DIV_ROUND_NEAREST_EN
    function automatic logic [MAN_W:0] round_ne(input logic [MAN_W-1:0] m,
                                                input logic g,
                                                input logic s);
        return {1'b0, m} + (MAN_W+1)'(g & (s | m[0]));
    endfunction

    logic guard, sticky, carry;
`else
    logic unused_bits;
    assign unused_bits = ^{q[0], rem_nz};
`endif

    assign cls  = fp_div_classify(a[W-2:MAN_W], b[W-2:MAN_W]);
    assign busy = (state != IDLE);

    fp_div_mant_core #(.MAN_W(MAN_W)) u_core (
        .clk         (clk),
        .load        (load),
        .step        (step),
        .ma          (a[MAN_W-1:0]),
        .mb          (b[MAN_W-1:0]),
        .q           (q),
        .rem_nonzero (rem_nz),
        .last        (last)
    );

    always_comb begin
        state_nxt = state;
        acc       = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: begin
                // done is still high in the cycle right after completion; that start is dropped
                if (start && !done) begin
                    acc = 1'b1;
                    if (cls != CLS_NORM) begin
                        state_nxt = SPEC;
                    end else begin
                        load      = 1'b1;
                        state_nxt = DIV;
                    end
                end
            end
            DIV: begin
                step = 1'b1;
                if (last) state_nxt = NORM;
            end
            NORM: begin
                fin       = 1'b1;
                state_nxt = IDLE;
            end
            SPEC: begin
                fin       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        if (q[Q-1]) begin
            mant = q[Q-2:2];
            e_n  = e_base;
        end else begin
            mant = q[Q-3:1];
            e_n  = e_base - ONE_E;
        end
`ifdef FP_DIV_ROUND_NEAREST_EN
        guard  = q[Q-1] ? q[1] : q[0];
        sticky = q[Q-1] ? (q[0] | rem_nz) : rem_nz;
        {carry, mant_rd} = round_ne(mant, guard, sticky);
        e_rd = e_n + $signed({{(EXP_W+1){1'b0}}, carry});
`else
        mant_rd = mant;
        e_rd    = e_n;
`endif
        norm_res = pack_res(sign_r, e_rd, mant_rd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
            out   <= '0;
        end else begin
            state <= state_nxt;
            done  <= fin;
            if (fin) out <= (state == SPEC) ? spec_r : norm_res;
        end
    end

    // Operand-derived fields, captured on the accepting edge
    always_ff @(posedge clk) begin
        if (acc) begin
            sign_r <= a[W-1] ^ b[W-1];
            e_base <= $signed({2'b00, a[W-2:MAN_W]}) - $signed({2'b00, b[W-2:MAN_W]}) + BIAS_E;
            spec_r <= (cls == CLS_ZERO) ? FP_ZERO : FP_INF;
        end
    end

endmodule

// File: tb/tb_fp_divider.sv
// Directed-vector bench for fp_divider: result, latency, busy/done handshake and control corners.
module tb_fp_divider;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] a, b, out;
    logic        busy, done;
    int          total = 0;
    int          bad   = 0;

    fp_divider dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Cycle 1 is the cycle containing the accepting edge; lat is the cycle in which done is seen.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input int again_at,
                          output logic [31:0] res, output int lat,
                          output bit busy_ok, output bit pulse_ok);
        a = ta; b = tb_; start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        lat     = 1;
        busy_ok = 1'b1;
        while (!done && lat < 60) begin
            if (!busy) busy_ok = 1'b0;
            if (lat == again_at) begin
                a = 32'h4120_0000; b = 32'h3F80_0000; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        if (!done) lat = -1;
        if (busy) busy_ok = 1'b0;
        res = out;
        @(posedge clk); #1;
        pulse_ok = !done && !busy && (out === res);
    endtask

    initial begin
        logic [31:0] res;
        int          lat, cyc;
        bit          busy_ok, pulse_ok;

        vecs[0]  = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 28, "six_div_two"};
`ifdef FP_DIV_ROUND_NEAREST_EN
        vecs[1]  = '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 28, "one_third"};
`else
        vecs[1]  = '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 28, "one_third"};
`endif
        vecs[2]  = '{32'hC0F0_0000, 32'h4020_0000, 32'hC040_0000, 28, "neg_pos"};
        vecs[3]  = '{32'hC0F0_0000, 32'hC020_0000, 32'h4040_0000, 28, "neg_neg"};
        vecs[4]  = '{32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 2,  "zero_dividend"};
        vecs[5]  = '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 2,  "zero_divisor"};
        vecs[6]  = '{32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 2,  "inf_dividend"};
        vecs[7]  = '{32'hBF80_0000, 32'h7FC0_0000, 32'h7F80_0000, 2,  "nan_divisor"};
        vecs[8]  = '{32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 28, "overflow"};
        vecs[9]  = '{32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 28, "underflow"};
        vecs[10] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 28, "one_div_one"};

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_out", out, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].a, vecs[i].b, -1, res, lat, busy_ok, pulse_ok);
            check({vecs[i].name, "_out"}, res, vecs[i].q);
            check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
            check({vecs[i].name, "_busy"}, {31'b0, busy_ok}, 32'd1);
            check({vecs[i].name, "_pulse"}, {31'b0, pulse_ok}, 32'd1);
        end

        // start re-asserted mid-operation must not disturb the result
        run_op(32'h40C0_0000, 32'h4000_0000, 5, res, lat, busy_ok, pulse_ok);
        check("restart_out", res, 32'h4040_0000);
        check("restart_lat", 32'(lat), 32'd28);

        // start in the done cycle is dropped
        a = 32'h4000_0000; b = 32'h0000_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("spec_seq_lat", 32'(cyc), 32'd2);
        a = 32'h40C0_0000; b = 32'h4000_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_cycle_start_busy", {31'b0, busy}, 32'd0);
        check("done_cycle_start_out", out, 32'h7F80_0000);

        // reset in the middle of an operation, with start held high alongside it
        a = 32'h3F80_0000; b = 32'h4040_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_out", out, 32'd0);
        @(posedge clk); #1;
        check("midrst_start_dropped", {31'b0, busy}, 32'd0);

        run_op(32'h40C0_0000, 32'h4000_0000, -1, res, lat, busy_ok, pulse_ok);
        check("post_rst_out", res, 32'h4040_0000);
        check("post_rst_lat", 32'(lat), 32'd28);
        check("post_rst_busy", {31'b0, busy_ok}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
